// File: rtl/calc_mux_pkg.sv
// Shared constants and helpers for the calculator's word/bit select muxes.
package calc_mux_pkg;

    localparam int MAX_INPUTS = 16;
    localparam int ARB_FIXED  = 0;
    localparam int ARB_RR     = 1;

    // Index width for an n-way select, never narrower than one bit.
    function automatic int sel_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/word_arb_mux_rr_arbiter.sv
// Request arbiter: fixed priority (lowest index) or round-robin from ptr.
// Also produces the pointer value to load after a granted transfer.
module rr_arbiter
    import calc_mux_pkg::*;
#(
    parameter int N       = 4,
    parameter int RR_MODE = ARB_RR,
    parameter int W       = sel_width(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic         advance,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx,
    output logic [W-1:0] next_ptr
);

    // First requester found scanning upward from the start index, with wrap.
    always_comb begin
        int   base;
        int   c;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        base      = (RR_MODE == ARB_RR) ? int'(ptr) : 0;
        for (int i = 0; i < N; i++) begin
            c = base + i;
            if (c >= N) c = c - N;
            if (!found && req[c]) begin
                found     = 1'b1;
                grant[c]  = 1'b1;
                grant_idx = W'(c);
            end
        end
    end

    // Pointer moves one past the winner; explicit wrap covers non-power-of-two N.
    always_comb begin
        next_ptr = ptr;
        if (RR_MODE == ARB_RR && advance) begin
            next_ptr = (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/word_arb_mux.sv
// Registered N-to-1 word mux with valid/ready handshake and built-in
// arbitration. Holds one word in the output register under back-pressure.
module word_arb_mux
    import calc_mux_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_WIDTH = 8,
    parameter int RR_MODE    = ARB_RR,
    parameter int SEL_W      = sel_width(NUM_INPUTS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_INPUTS-1:0]            in_valid,
    output logic [NUM_INPUTS-1:0]            in_ready,
    input  logic                             force_en,
    input  logic [SEL_W-1:0]                 force_sel,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [SEL_W-1:0]                 out_sel,
    output logic                             out_valid,
    input  logic                             out_ready
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t                                state_q, state_d;
    logic [SEL_W-1:0]                      ptr_q, ptr_d;
    logic [NUM_INPUTS-1:0]                 elig, grant;
    logic [SEL_W-1:0]                      grant_idx;
    logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] words;
    logic                                  load_en, xfer;

    assign words     = in_data;
    assign out_valid = (state_q == FULL);
    assign load_en   = !out_valid || out_ready;

    // Eligible set: all valid channels, or only the forced one (none if out of range).
    always_comb begin
        elig = in_valid;
        if (force_en) begin
            elig = '0;
            if (int'(force_sel) < NUM_INPUTS) elig[force_sel] = in_valid[force_sel];
        end
    end

    rr_arbiter #(
        .N       (NUM_INPUTS),
        .RR_MODE (RR_MODE),
        .W       (SEL_W)
    ) u_arb (
        .req       (elig),
        .ptr       (ptr_q),
        .advance   (xfer),
        .grant     (grant),
        .grant_idx (grant_idx),
        .next_ptr  (ptr_d)
    );

    // Grant is already zero when nothing is eligible; ready is blocked in reset.
    assign in_ready = (load_en && !rst) ? grant : '0;
    assign xfer     = |in_ready;

    // Output-stage state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    // FULL/EMPTY next state: a transfer always fills, a lone handshake drains.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (xfer) state_d = FULL;
            FULL:    if (xfer) state_d = FULL;
                     else if (out_ready) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Output word/index register; only a transfer writes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
            out_sel  <= '0;
        end else if (xfer) begin
            out_data <= words[grant_idx];
            out_sel  <= grant_idx;
        end
    end

    // Round-robin pointer; the arbiter holds it unless a transfer happens.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: tb/tb_word_arb_mux.sv
// Bench for word_arb_mux: three instances (N=4 RR, N=4 fixed, N=3 RR)
// sharing clock and reset, scoreboard queues checked at output handshake.
module tb_word_arb_mux;

    typedef struct {
        logic [1:0] sel;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    logic [31:0] d_rr, d_fx;
    logic [23:0] d_n3;
    logic [3:0]  v_rr, r_rr, v_fx, r_fx;
    logic [2:0]  v_n3, r_n3;
    logic        fe_rr, fe_fx, fe_n3;
    logic [1:0]  fs_rr, fs_fx, fs_n3;
    logic [7:0]  od_rr, od_fx, od_n3;
    logic [1:0]  os_rr, os_fx, os_n3;
    logic        ov_rr, ov_fx, ov_n3;
    logic        or_rr, or_fx, or_n3;

    exp_t q_rr[$];
    exp_t q_fx[$];
    exp_t q_n3[$];
    exp_t e;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [1:0] m_ptr;
    logic [7:0] words [4] = '{8'h10, 8'h21, 8'h32, 8'h43};

    always #5 clk = ~clk;

    word_arb_mux #(.NUM_INPUTS(4), .DATA_WIDTH(8), .RR_MODE(1)) u_rr (
        .clk(clk), .rst(rst), .in_data(d_rr), .in_valid(v_rr), .in_ready(r_rr),
        .force_en(fe_rr), .force_sel(fs_rr), .out_data(od_rr), .out_sel(os_rr),
        .out_valid(ov_rr), .out_ready(or_rr));

    word_arb_mux #(.NUM_INPUTS(4), .DATA_WIDTH(8), .RR_MODE(0)) u_fx (
        .clk(clk), .rst(rst), .in_data(d_fx), .in_valid(v_fx), .in_ready(r_fx),
        .force_en(fe_fx), .force_sel(fs_fx), .out_data(od_fx), .out_sel(os_fx),
        .out_valid(ov_fx), .out_ready(or_fx));

    word_arb_mux #(.NUM_INPUTS(3), .DATA_WIDTH(8), .RR_MODE(1)) u_n3 (
        .clk(clk), .rst(rst), .in_data(d_n3), .in_valid(v_n3), .in_ready(r_n3),
        .force_en(fe_n3), .force_sel(fs_n3), .out_data(od_n3), .out_sel(os_n3),
        .out_valid(ov_n3), .out_ready(or_n3));

    task automatic test_reset();
        rst = 1'b1;
        v_rr = 4'b1111; or_rr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            total_cnt++;
            if (ov_rr !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", ov_rr);
            else pass_cnt++;
            total_cnt++;
            if (r_rr !== 4'b0000) $display("FAIL reset_in_ready got %b want 0000", r_rr);
            else pass_cnt++;
            total_cnt++;
            if (od_rr !== 8'h00) $display("FAIL reset_out_data got %h want 00", od_rr);
            else pass_cnt++;
        end
        @(negedge clk);
        rst = 1'b0;
        m_ptr = 2'd0;
    endtask

    // All four channels valid: grants rotate 0,1,2,3,0,... one per cycle.
    task automatic test_rr_fair();
        for (int i = 0; i < 6; i++) begin
            #1;
            if (ov_rr && or_rr) begin
                total_cnt++;
                if (q_rr.size() == 0) $display("FAIL rr_underflow got word with empty queue");
                else begin
                    e = q_rr.pop_front();
                    if (os_rr !== e.sel || od_rr !== e.data)
                        $display("FAIL rr_seq got sel=%0d data=%h want sel=%0d data=%h", os_rr, od_rr, e.sel, e.data);
                    else pass_cnt++;
                end
            end else if (i > 0) begin
                total_cnt++;
                $display("FAIL rr_throughput got out_valid=%0b want 1 at step %0d", ov_rr, i);
            end
            total_cnt++;
            if (r_rr !== (4'b0001 << m_ptr)) $display("FAIL rr_in_ready got %b want %b", r_rr, 4'b0001 << m_ptr);
            else pass_cnt++;
            q_rr.push_back('{sel: m_ptr, data: words[m_ptr]});
            m_ptr = m_ptr + 2'd1;
            @(negedge clk);
        end
        // Stop issuing and drain the last word.
        v_rr = 4'b0000;
        #1;
        total_cnt++;
        if (!(ov_rr && or_rr) || q_rr.size() == 0) $display("FAIL rr_drain got out_valid=%0b want 1", ov_rr);
        else begin
            e = q_rr.pop_front();
            if (os_rr !== e.sel || od_rr !== e.data)
                $display("FAIL rr_last got sel=%0d data=%h want sel=%0d data=%h", os_rr, od_rr, e.sel, e.data);
            else pass_cnt++;
        end
        @(negedge clk);
    endtask

    // Channels 1 and 3 valid, fixed priority: channel 1 wins every cycle.
    task automatic test_fixed();
        v_fx = 4'b1010; or_fx = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (ov_fx && or_fx) begin
                total_cnt++;
                e = q_fx.pop_front();
                if (os_fx !== e.sel || od_fx !== e.data)
                    $display("FAIL fixed_seq got sel=%0d data=%h want sel=%0d data=%h", os_fx, od_fx, e.sel, e.data);
                else pass_cnt++;
            end
            total_cnt++;
            if (r_fx !== 4'b0010) $display("FAIL fixed_in_ready got %b want 0010", r_fx);
            else pass_cnt++;
            q_fx.push_back('{sel: 2'd1, data: 8'h21});
            @(negedge clk);
        end
        v_fx = 4'b0000;
        #1;
        total_cnt++;
        if (!(ov_fx && or_fx) || q_fx.size() == 0) $display("FAIL fixed_drain got out_valid=%0b want 1", ov_fx);
        else begin
            e = q_fx.pop_front();
            if (os_fx !== e.sel || od_fx !== e.data)
                $display("FAIL fixed_last got sel=%0d data=%h want sel=%0d data=%h", os_fx, od_fx, e.sel, e.data);
            else pass_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        d_rr[7:0] = 8'hA5;
        v_rr = 4'b0001; or_rr = 1'b0;
        #1;
        total_cnt++;
        if (r_rr !== 4'b0001) $display("FAIL bp_load_ready got %b want 0001", r_rr);
        else pass_cnt++;
        q_rr.push_back('{sel: 2'd0, data: 8'hA5});
        @(negedge clk);
        // Channel 1 pending while the output is stalled.
        v_rr = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            #1;
            total_cnt++;
            if (od_rr !== 8'hA5 || os_rr !== 2'd0 || ov_rr !== 1'b1)
                $display("FAIL bp_hold got data=%h sel=%0d valid=%0b want A5/0/1", od_rr, os_rr, ov_rr);
            else pass_cnt++;
            total_cnt++;
            if (r_rr !== 4'b0000) $display("FAIL bp_in_ready got %b want 0000", r_rr);
            else pass_cnt++;
            @(negedge clk);
        end
        or_rr = 1'b1;
        #1;
        total_cnt++;
        if (r_rr !== 4'b0010) $display("FAIL bp_release_ready got %b want 0010", r_rr);
        else pass_cnt++;
        total_cnt++;
        e = q_rr.pop_front();
        if (od_rr !== e.data || os_rr !== e.sel)
            $display("FAIL bp_accept got sel=%0d data=%h want sel=%0d data=%h", os_rr, od_rr, e.sel, e.data);
        else pass_cnt++;
        q_rr.push_back('{sel: 2'd1, data: 8'h21});
        @(negedge clk);
        v_rr = 4'b0000;
        #1;
        total_cnt++;
        if (ov_rr !== 1'b1) $display("FAIL bp_no_bubble got out_valid=%0b want 1", ov_rr);
        else begin
            e = q_rr.pop_front();
            if (od_rr !== e.data || os_rr !== e.sel)
                $display("FAIL bp_next got sel=%0d data=%h want sel=%0d data=%h", os_rr, od_rr, e.sel, e.data);
            else pass_cnt++;
        end
        @(negedge clk); #1;
        total_cnt++;
        if (ov_rr !== 1'b0 || od_rr !== 8'h21 || os_rr !== 2'd1)
            $display("FAIL bp_drained got valid=%0b data=%h sel=%0d want 0/21/1", ov_rr, od_rr, os_rr);
        else pass_cnt++;
    endtask

    // N=3: forced channel 2, pointer wraps to 0; out-of-range force grants nothing.
    task automatic test_force_wrap();
        @(negedge clk);
        v_n3 = 3'b111; or_n3 = 1'b1; fe_n3 = 1'b1; fs_n3 = 2'd2;
        #1;
        total_cnt++;
        if (r_n3 !== 3'b100) $display("FAIL force_ready got %b want 100", r_n3);
        else pass_cnt++;
        q_n3.push_back('{sel: 2'd2, data: 8'h32});
        @(negedge clk);
        fe_n3 = 1'b0;
        #1;
        total_cnt++;
        if (r_n3 !== 3'b001) $display("FAIL force_wrap_ptr got %b want 001", r_n3);
        else pass_cnt++;
        total_cnt++;
        e = q_n3.pop_front();
        if (ov_n3 !== 1'b1 || os_n3 !== e.sel || od_n3 !== e.data)
            $display("FAIL force_out got valid=%0b sel=%0d data=%h want 1/%0d/%h", ov_n3, os_n3, od_n3, e.sel, e.data);
        else pass_cnt++;
        q_n3.push_back('{sel: 2'd0, data: 8'h10});
        @(negedge clk);
        fe_n3 = 1'b1; fs_n3 = 2'd3;
        #1;
        total_cnt++;
        if (r_n3 !== 3'b000) $display("FAIL force_oob_ready got %b want 000", r_n3);
        else pass_cnt++;
        total_cnt++;
        e = q_n3.pop_front();
        if (ov_n3 !== 1'b1 || os_n3 !== e.sel || od_n3 !== e.data)
            $display("FAIL force_pending got valid=%0b sel=%0d data=%h want 1/%0d/%h", ov_n3, os_n3, od_n3, e.sel, e.data);
        else pass_cnt++;
        @(negedge clk); #1;
        total_cnt++;
        if (ov_n3 !== 1'b0 || r_n3 !== 3'b000) $display("FAIL force_oob_drain got valid=%0b ready=%b want 0/000", ov_n3, r_n3);
        else pass_cnt++;
        v_n3 = 3'b000; fe_n3 = 1'b0; fs_n3 = 2'd0;
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        d_rr[7:0] = 8'hA5;
        v_rr = 4'b0001; or_rr = 1'b0;
        #1;
        q_rr.push_back('{sel: 2'd0, data: 8'hA5});
        @(negedge clk);
        v_rr = 4'b0000;
        #1;
        total_cnt++;
        if (ov_rr !== 1'b1) $display("FAIL mr_loaded got out_valid=%0b want 1", ov_rr);
        else pass_cnt++;
        #1 rst = 1'b1;
        #1;
        q_rr.delete();
        total_cnt++;
        if (ov_rr !== 1'b0 || od_rr !== 8'h00 || r_rr !== 4'b0000)
            $display("FAIL mr_async got valid=%0b data=%h ready=%b want 0/00/0000", ov_rr, od_rr, r_rr);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        v_rr = 4'b1111; or_rr = 1'b1;
        #1;
        total_cnt++;
        if (r_rr !== 4'b0001 || ov_rr !== 1'b0)
            $display("FAIL mr_ptr got ready=%b valid=%0b want 0001/0", r_rr, ov_rr);
        else pass_cnt++;
        v_rr = 4'b0000;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        d_rr = {words[3], words[2], words[1], words[0]};
        d_fx = d_rr;
        d_n3 = {words[2], words[1], words[0]};
        v_rr = '0; v_fx = '0; v_n3 = '0;
        fe_rr = 1'b0; fe_fx = 1'b0; fe_n3 = 1'b0;
        fs_rr = '0; fs_fx = '0; fs_n3 = '0;
        or_rr = 1'b1; or_fx = 1'b1; or_n3 = 1'b1;
        test_reset();
        test_rr_fair();
        test_fixed();
        d_rr = {words[3], words[2], words[1], words[0]};
        test_back_to_back();
        test_force_wrap();
        test_mid_reset();
        total_cnt++;
        if (q_rr.size() != 0 || q_fx.size() != 0 || q_n3.size() != 0)
            $display("FAIL scoreboard_leftover got %0d/%0d/%0d want 0/0/0", q_rr.size(), q_fx.size(), q_n3.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
